// File: rtl/mem_load_pkg.sv
// Shared definitions for the load-return path: load-op encodings, FSM states,
// and the alignment rule used to raise the address-error-on-load flag.
// No ports; imported by mem_load_unit and load_extend.
package mem_load_pkg;

    // Width of the load-op encoding as issued by decode.
    localparam int OP_W = 3;

    // Load-op encodings. Anything not listed here is formatted as LW.
    localparam logic [OP_W-1:0] LB  = 3'd0;
    localparam logic [OP_W-1:0] LBU = 3'd1;
    localparam logic [OP_W-1:0] LH  = 3'd2;
    localparam logic [OP_W-1:0] LHU = 3'd3;
    localparam logic [OP_W-1:0] LW  = 3'd4;

    // IDLE: nothing in flight. DATA: result formatted from the live SRAM read
    // bus. HOLD: result formatted from the captured buffer (write-back stalled).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Halfwords must sit on a 2-byte boundary, words on a 4-byte boundary.
    function automatic logic is_misaligned(input logic       is_half,
                                           input logic       is_word,
                                           input logic [1:0] addr_lo);
        return (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Purpose: select byte/halfword/word from a raw little-endian read word, then sign/zero-extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows inputs.
// Ports: raw_i (32b read word), op_i (load op), addr_lo_i (byte offset),
//        data_o (formatted data, 0 on misalignment), adel_o (misaligned flag).
module load_extend
    import mem_load_pkg::*;
#(
    parameter int LOAD_OP_W = OP_W
) (
    input  logic [31:0]          raw_i,
    input  logic [LOAD_OP_W-1:0] op_i,
    input  logic [1:0]           addr_lo_i,
    output logic [31:0]          data_o,
    output logic                 adel_o
);

    logic        is_lb, is_lbu, is_lh, is_lhu, is_half, is_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] fmt;

    assign is_lb   = (op_i == LOAD_OP_W'(LB));
    assign is_lbu  = (op_i == LOAD_OP_W'(LBU));
    assign is_lh   = (op_i == LOAD_OP_W'(LH));
    assign is_lhu  = (op_i == LOAD_OP_W'(LHU));
    assign is_half = is_lh | is_lhu;
    // Every unrecognised encoding behaves as LW, including for alignment.
    assign is_word = ~(is_lb | is_lbu | is_half);

    always_comb begin
        byte_sel = raw_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
    end

    assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

    always_comb begin
        fmt = raw_i;
        if (is_lb)       fmt = {{24{byte_sel[7]}}, byte_sel};
        else if (is_lbu) fmt = {24'h0, byte_sel};
        else if (is_lh)  fmt = {{16{half_sel[15]}}, half_sel};
        else if (is_lhu) fmt = {16'h0, half_sel};
    end

    assign adel_o = is_misaligned(is_half, is_word, addr_lo_i);
    assign data_o = adel_o ? 32'h0 : fmt;

endmodule

// File: rtl/mem_load_unit.sv
// Purpose: capture, align and extend the SRAM read word for a load and hand it to write-back.
// Latency: 1 cycle from descriptor accept to out_valid; 1 load/cycle sustained.
// Backpressure: out_ready low parks the raw word in a buffer (HOLD) and drops in_ready.
// Ports: in_* load descriptor (valid/ready), flush kills in-flight load,
//        sram_rdata read word (valid the cycle after request), out_* result (valid/ready).
module mem_load_unit
    import mem_load_pkg::*;
#(
    parameter int LOAD_OP_W = OP_W,
    parameter int DEST_W    = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOAD_OP_W-1:0] in_load_op,
    input  logic [1:0]           in_addr_lo,
    input  logic [DEST_W-1:0]    in_dest,
    input  logic                 flush,
    input  logic [31:0]          sram_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [DEST_W-1:0]    out_dest,
    output logic                 out_adel
);

    state_e                state_q, state_d;
    logic [LOAD_OP_W-1:0]  op_q;
    logic [1:0]            addr_q;
    logic [DEST_W-1:0]     dest_q;
    logic [31:0]           buf_q;

    logic                  accept;
    logic                  buf_en;
    logic [31:0]           raw;
    logic [31:0]           ext_data;
    logic                  ext_adel;

    // Any retiring result frees the slot, so a new load can chain in the same cycle.
    assign in_ready = (state_q == ST_IDLE) | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // The SRAM read bus is only good for one cycle; capture it when write-back
    // does not take the result in DATA.
    assign buf_en   = (state_q == ST_DATA) & ~out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept ? ST_DATA : ST_IDLE;
            ST_DATA: begin
                if (out_ready) state_d = accept ? ST_DATA : ST_IDLE;
                else           state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) state_d = accept ? ST_DATA : ST_IDLE;
                else           state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            dest_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= in_load_op;
                addr_q <= in_addr_lo;
                dest_q <= in_dest;
            end
            if (buf_en) buf_q <= sram_rdata;
        end
    end

    assign raw = (state_q == ST_HOLD) ? buf_q : sram_rdata;

    load_extend #(
        .LOAD_OP_W (LOAD_OP_W)
    ) u_extend (
        .raw_i     (raw),
        .op_i      (op_q),
        .addr_lo_i (addr_q),
        .data_o    (ext_data),
        .adel_o    (ext_adel)
    );

    // Outputs are squashed to zero whenever no result is presented.
    assign out_valid = (state_q != ST_IDLE);
    assign out_adel  = out_valid & ext_adel;
    assign out_data  = out_valid ? ext_data : 32'h0;
    assign out_dest  = out_valid ? dest_q : '0;

endmodule

// File: tb/tb_mem_load_unit.sv
module tb_mem_load_unit;
    import mem_load_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_load_op;
    logic [1:0]  in_addr_lo;
    logic [4:0]  in_dest;
    logic        flush;
    logic [31:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic        out_adel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_load_unit #(.LOAD_OP_W(3), .DEST_W(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load_op (in_load_op),
        .in_addr_lo (in_addr_lo),
        .in_dest    (in_dest),
        .flush      (flush),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .out_adel   (out_adel)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  addr;
        logic [4:0]  dest;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_adel;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid   = 1'b0;
        in_load_op = 3'd0;
        in_addr_lo = 2'd0;
        in_dest    = 5'd0;
        flush      = 1'b0;
    endtask

    task automatic present(input logic [2:0] op, input logic [1:0] a, input logic [4:0] d);
        in_valid   = 1'b1;
        in_load_op = op;
        in_addr_lo = a;
        in_dest    = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, ".out_data"},  out_data, 32'h0);
        check({tag, ".out_dest"},  {27'h0, out_dest}, 32'h0);
        check({tag, ".out_adel"},  {31'h0, out_adel}, 32'h0);
        check({tag, ".in_ready"},  {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        vecs[0]  = '{LB,   2'd3, 5'd1,  32'h80123456, 32'hFFFFFF80, 1'b0};
        vecs[1]  = '{LHU,  2'd2, 5'd2,  32'hBEEF1234, 32'h0000BEEF, 1'b0};
        vecs[2]  = '{LH,   2'd2, 5'd3,  32'hBEEF1234, 32'hFFFFBEEF, 1'b0};
        vecs[3]  = '{LW,   2'd2, 5'd4,  32'h11223344, 32'h00000000, 1'b1};
        vecs[4]  = '{LH,   2'd1, 5'd5,  32'h11223344, 32'h00000000, 1'b1};
        vecs[5]  = '{LBU,  2'd1, 5'd6,  32'h80123456, 32'h00000034, 1'b0};
        vecs[6]  = '{LB,   2'd0, 5'd8,  32'h1234567F, 32'h0000007F, 1'b0};
        vecs[7]  = '{LH,   2'd0, 5'd9,  32'h12348001, 32'hFFFF8001, 1'b0};
        vecs[8]  = '{LW,   2'd0, 5'd10, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{3'd7, 2'd0, 5'd31, 32'h01020304, 32'h01020304, 1'b0};
        vecs[10] = '{LHU,  2'd3, 5'd12, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[11] = '{3'd6, 2'd1, 5'd13, 32'h01020304, 32'h00000000, 1'b1};

        // Reset state
        resetn     = 1'b0;
        out_ready  = 1'b1;
        sram_rdata = 32'h0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Single loads from the table, out_ready held high
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            present(vecs[i].op, vecs[i].addr, vecs[i].dest);
            out_ready  = 1'b1;
            sram_rdata = $urandom;
            #1;
            check($sformatf("v%0d.idle_valid", i), {31'h0, out_valid}, 32'h0);
            @(negedge clk);
            drive_idle();
            sram_rdata = vecs[i].rdata;
            #1;
            check($sformatf("v%0d.valid", i), {31'h0, out_valid}, 32'h1);
            check($sformatf("v%0d.data", i),  out_data, vecs[i].exp_data);
            check($sformatf("v%0d.adel", i),  {31'h0, out_adel}, {31'h0, vecs[i].exp_adel});
            check($sformatf("v%0d.dest", i),  {27'h0, out_dest}, {27'h0, vecs[i].dest});
        end

        // Stall: LW held through 3 stalled cycles while the SRAM bus changes
        @(negedge clk);
        present(LW, 2'd0, 5'd7);
        @(negedge clk);
        drive_idle();
        out_ready  = 1'b0;
        sram_rdata = 32'h11223344;
        #1;
        check("stall.first_data", out_data, 32'h11223344);
        check("stall.first_rdy",  {31'h0, in_ready}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sram_rdata = 32'hDEADBEEF;
            present(LB, 2'd1, 5'd9);   // must not be taken while stalled
            #1;
            check($sformatf("stall%0d.valid", c), {31'h0, out_valid}, 32'h1);
            check($sformatf("stall%0d.data", c),  out_data, 32'h11223344);
            check($sformatf("stall%0d.rdy", c),   {31'h0, in_ready}, 32'h0);
            check($sformatf("stall%0d.dest", c),  {27'h0, out_dest}, 32'd7);
        end
        @(negedge clk);
        drive_idle();
        out_ready = 1'b1;
        #1;
        check("release.valid", {31'h0, out_valid}, 32'h1);
        check("release.data",  out_data, 32'h11223344);
        @(negedge clk);
        #1;
        check("release.idle", {31'h0, out_valid}, 32'h0);

        // Four back-to-back LBU with no bubbles
        @(negedge clk);
        present(LBU, 2'd0, 5'd1);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] expb [4];
            expb[0] = 32'hD4; expb[1] = 32'hC3; expb[2] = 32'hB2; expb[3] = 32'hA1;
            @(negedge clk);
            if (k < 3) present(LBU, 2'(k + 1), 5'(k + 2));
            else       drive_idle();
            sram_rdata = 32'hA1B2C3D4;
            #1;
            check($sformatf("b2b%0d.valid", k), {31'h0, out_valid}, 32'h1);
            check($sformatf("b2b%0d.data", k),  out_data, expb[k]);
            check($sformatf("b2b%0d.dest", k),  {27'h0, out_dest}, 32'(k + 1));
        end
        @(negedge clk);
        #1;
        check("b2b.idle", {31'h0, out_valid}, 32'h0);

        // Flush while in HOLD: same-cycle descriptor must be dropped
        @(negedge clk);
        present(LW, 2'd0, 5'd3);
        @(negedge clk);
        drive_idle();
        out_ready  = 1'b0;
        sram_rdata = 32'h55667788;
        @(negedge clk);
        sram_rdata = 32'h0;
        #1;
        check("flush.hold_data", out_data, 32'h55667788);
        @(negedge clk);
        present(LB, 2'd0, 5'd4);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush.in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        drive_idle();
        #1;
        check("flush.out_valid", {31'h0, out_valid}, 32'h0);
        check("flush.out_dest",  {27'h0, out_dest}, 32'h0);

        // Asynchronous reset mid-DATA
        @(negedge clk);
        present(LW, 2'd0, 5'd11);
        @(negedge clk);
        drive_idle();
        out_ready  = 1'b0;
        sram_rdata = 32'h12345678;
        #1;
        check("rst.pre_valid", {31'h0, out_valid}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst.after_valid", {31'h0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Load-return stage downstream of the data-SRAM interface: accepts a load descriptor in the cycle its address is presented to the synchronous data SRAM, then captures, aligns and sign/zero-extends the SRAM read word returned one cycle later and delivers it to write-back over a valid/ready handshake. When write-back stalls, the block buffers the raw word, because the SRAM read bus is only valid for the cycle after the request. Non-load instructions bypass this block.

## Interface
- LOAD_OP_W, 3, width of the load-op encoding (encodings in mem_load_pkg)
- DEST_W, 5, destination register index width
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  load descriptor present (address presented to SRAM this cycle)
- in_ready  out  1  block can accept the descriptor this cycle
- in_load_op  in  LOAD_OP_W  LB=0, LBU=1, LH=2, LHU=3, LW=4; others treated as LW
- in_addr_lo  in  2  physical address bits [1:0]
- in_dest  in  DEST_W  destination register
- flush  in  1  exception/flush from the commit point; kills the in-flight load
- sram_rdata  in  32  data-SRAM read word, valid the cycle after the request
- out_valid  out  1  load result available
- out_ready  in  1  write-back accepts the result
- out_data  out  32  aligned, extended load data; 0 when out_valid=0 or out_adel=1
- out_dest  out  DEST_W  destination register; 0 when out_valid=0
- out_adel  out  1  address-error-on-load flag (misaligned LH/LHU/LW)

## Operation
- States: IDLE (nothing in flight), DATA (result drives from sram_rdata), HOLD (result drives from the internal 32-bit buffer).
- Accept = in_valid & in_ready & ~flush; latch op, addr_lo and dest into meta registers.
- in_ready = (state==IDLE) | out_ready.
- Transitions:
  - IDLE: accept -> DATA; otherwise stay.
  - DATA, out_ready=1: accept -> DATA; otherwise -> IDLE.
  - DATA, out_ready=0: copy sram_rdata into the buffer -> HOLD.
  - HOLD, out_ready=1: accept -> DATA; otherwise -> IDLE.
  - HOLD, out_ready=0: stay, buffer unchanged.
- out_valid = state != IDLE.
- Raw word is sram_rdata in DATA and the buffer in HOLD.
- Formatting, little-endian:
  - byte = raw[8*addr_lo +: 8];
  - half = raw[16*addr_lo[1] +: 16];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Misaligned access: LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0, sets out_adel=1 and forces out_data=0. The result still handshakes normally.
- flush: next state IDLE regardless of the current state; the buffer is not cleared but becomes unobservable. in_ready may be high during flush, but nothing is accepted.
- Simultaneous release and accept (DATA/HOLD with out_ready=1 and a new accept): old result retires this cycle, new result becomes valid next cycle with no bubble.

## Timing
- Latency: accept at cycle T -> out_valid at T+1, with data taken from sram_rdata sampled in T+1.
- Throughput: 1 load/cycle while out_ready=1.
- Stall capture: entering HOLD, the buffer samples sram_rdata at the T+1 edge. Later changes on sram_rdata never affect out_data while in HOLD.
- Reset (asynchronous, any state including mid-HOLD): state=IDLE, meta=0, buffer=0. Outputs: out_valid=0, out_data=0, out_dest=0, out_adel=0, in_ready=1.
- Outputs are combinational from state, meta and raw word. There is no combinational path from in_* to out_*. in_ready depends combinationally on out_ready.

## Structure
- mem_load_pkg: load-op localparams (LB..LW), state encoding (IDLE/DATA/HOLD), misalignment check function.
- Sub-module load_extend: purely combinational raw word + op + addr_lo -> {data, adel}. Reused by any future uncached load path.
- Top holds the FSM, meta registers and buffer.

## Test plan
- LB, addr_lo=3, sram_rdata=0x80123456, out_ready=1 -> T+1: out_valid=1, out_data=0xFFFFFF80, out_adel=0.
- LHU, addr_lo=2, sram_rdata=0xBEEF1234 -> out_data=0x0000BEEF. LH with the same inputs -> 0xFFFFBEEF.
- LW, dest=7, rdata=0x11223344; out_ready=0 for 3 cycles while sram_rdata changes to 0xDEADBEEF:
  - out_data holds 0x11223344 and in_ready=0;
  - on release, the result retires and IDLE follows.
- Four back-to-back LBU, addr_lo 0..3, on rdata 0xA1B2C3D4, out_ready=1 -> four consecutive cycles output 0xD4, 0xC3, 0xB2, 0xA1, with no bubbles.
- LW with addr_lo=2 -> out_adel=1, out_data=0; LH with addr_lo=1 -> out_adel=1.
- Flush and reset:
  - flush in HOLD -> out_valid=0 next cycle, and a same-cycle in_valid is not accepted;
  - resetn low mid-DATA -> all outputs 0 immediately, in_ready=1.
